// File: rtl/sd_multi_req_arbiter.sv
// Round-robin block-device request arbiter between the core's disk controllers and hps_io.
// Optional watchdog: define SD_REQ_TIMEOUT_EN to abort handshakes after TIMEOUT_CYCLES.
module sd_multi_req_arbiter #(
  parameter int unsigned    NCH            = 2,
  parameter logic [NCH-1:0] WAIT_MASK      = NCH'(2'b01),
  parameter logic [23:0]    TIMEOUT_CYCLES = 24'd5000000
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic [NCH-1:0] req_rd,
  input  logic [NCH-1:0] req_wr,
  input  logic [NCH-1:0] img_mounted,
  input  logic [63:0]    img_size,
  input  logic           img_readonly,
  input  logic [NCH-1:0] sd_ack,
  output logic [NCH-1:0] sd_rd,
  output logic [NCH-1:0] sd_wr,
  output logic [NCH-1:0] mounted,
  output logic [NCH-1:0] protect,
  output logic           cpu_wait,
  output logic           active,
  output logic [1:0]     active_ch,
  output logic [NCH-1:0] done,
  output logic [NCH-1:0] err
);

  typedef enum logic [1:0] {StIdle, StReq, StXfer} state_e;
  state_e state_q, state_d;

  logic [NCH-1:0] sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
  logic [NCH-1:0] mounted_q, mounted_d, protect_q, protect_d;
  logic [NCH-1:0] pending_rd_q, pending_rd_d, pending_wr_q, pending_wr_d;
  logic [NCH-1:0] ack_q, done_q, done_d, err_q, err_d;
  logic [1:0]     rr_q, rr_d, active_ch_q, active_ch_d;
  logic           active_q, active_d, cpu_wait_q, cpu_wait_d, issued_wr_q, issued_wr_d;

  logic [NCH-1:0] pend_any, ch_onehot, grant_onehot, rd_ok, wr_ok, pend_clr_rd, pend_clr_wr;
  logic [1:0]     grant_idx, grant_next;
  logic           grant_found, grant_rd, grant_wait, ack_rise, ack_fall, timeout;

  assign pend_any = pending_rd_q | pending_wr_q;

  // Round-robin scan: priority distance k from rr_q, first pending drive wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_rd    = 1'b0;
    grant_wait  = 1'b0;
    grant_next  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!grant_found && pend_any[i] && (((32'(rr_q) + k) % NCH) == i)) begin
          grant_found = 1'b1;
          grant_idx   = 2'(i);
          grant_rd    = pending_rd_q[i];
          grant_wait  = WAIT_MASK[i];
          grant_next  = 2'((i + 1) % NCH);
        end
      end
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      ch_onehot[i]    = (active_ch_q == 2'(i));
      grant_onehot[i] = grant_found && (grant_idx == 2'(i));
    end
  end

  // Edges are only meaningful on the granted drive.
  assign ack_rise = |(sd_ack & ~ack_q & ch_onehot);
  assign ack_fall = |(~sd_ack & ack_q & ch_onehot);

`ifdef SD_REQ_TIMEOUT_EN
  logic [23:0] timer_q, timer_d;

  assign timeout = (state_q != StIdle) && (timer_q == TIMEOUT_CYCLES - 24'd1);
  assign timer_d = (state_q == StIdle) ? 24'd0 : timer_q + 24'd1;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_found) state_d = StReq;
      StReq:   if (timeout) state_d = StIdle;
               else if (ack_rise) state_d = StXfer;
      StXfer:  if (timeout || ack_fall) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sd_rd_d     = sd_rd_q;
    sd_wr_d     = sd_wr_q;
    active_ch_d = active_ch_q;
    active_d    = active_q;
    cpu_wait_d  = cpu_wait_q;
    rr_d        = rr_q;
    issued_wr_d = issued_wr_q;
    mounted_d   = mounted_q;
    protect_d   = protect_q;
    done_d      = '0;
    pend_clr_rd = '0;
    pend_clr_wr = '0;
    rd_ok       = req_rd & mounted_q;
    wr_ok       = req_wr & mounted_q & ~protect_q;
    err_d       = (req_rd & ~rd_ok) | (req_wr & ~wr_ok);

    for (int unsigned i = 0; i < NCH; i++) begin
      if (img_mounted[i]) begin
        mounted_d[i] = |img_size;
        protect_d[i] = img_readonly;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          active_ch_d = grant_idx;
          active_d    = 1'b1;
          cpu_wait_d  = grant_wait;
          rr_d        = grant_next;
          sd_rd_d     = grant_rd ? grant_onehot : '0;
          sd_wr_d     = grant_rd ? '0 : grant_onehot;
          issued_wr_d = ~grant_rd;
        end
      end
      StReq, StXfer: begin
        if (timeout || (state_q == StReq && ack_rise)) begin
          sd_rd_d = '0;
          sd_wr_d = '0;
          // Pending bit is only still set for the issued type while in REQ.
          if (state_q == StReq) begin
            if (issued_wr_q) pend_clr_wr = ch_onehot;
            else             pend_clr_rd = ch_onehot;
          end
        end
        if (timeout) begin
          err_d      = err_d | ch_onehot;
          active_d   = 1'b0;
          cpu_wait_d = 1'b0;
        end else if (state_q == StXfer && ack_fall) begin
          done_d     = ch_onehot;
          active_d   = 1'b0;
          cpu_wait_d = 1'b0;
        end
      end
      default: ;
    endcase

    // New requests arriving alongside a clear are kept.
    pending_rd_d = (pending_rd_q & ~pend_clr_rd) | rd_ok;
    pending_wr_d = (pending_wr_q & ~pend_clr_wr) | wr_ok;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sd_rd_q      <= '0;
      sd_wr_q      <= '0;
      mounted_q    <= '0;
      protect_q    <= '0;
      pending_rd_q <= '0;
      pending_wr_q <= '0;
      ack_q        <= '0;
      done_q       <= '0;
      err_q        <= '0;
      rr_q         <= '0;
      active_ch_q  <= '0;
      active_q     <= 1'b0;
      cpu_wait_q   <= 1'b0;
      issued_wr_q  <= 1'b0;
    end else begin
      sd_rd_q      <= sd_rd_d;
      sd_wr_q      <= sd_wr_d;
      mounted_q    <= mounted_d;
      protect_q    <= protect_d;
      pending_rd_q <= pending_rd_d;
      pending_wr_q <= pending_wr_d;
      ack_q        <= sd_ack;
      done_q       <= done_d;
      err_q        <= err_d;
      rr_q         <= rr_d;
      active_ch_q  <= active_ch_d;
      active_q     <= active_d;
      cpu_wait_q   <= cpu_wait_d;
      issued_wr_q  <= issued_wr_d;
    end
  end

  assign sd_rd     = sd_rd_q;
  assign sd_wr     = sd_wr_q;
  assign mounted   = mounted_q;
  assign protect   = protect_q;
  assign cpu_wait  = cpu_wait_q;
  assign active    = active_q;
  assign active_ch = active_ch_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sd_multi_req_arbiter.sv
// Self-checking bench for sd_multi_req_arbiter: scoreboard of expected done/err completions.
module tb_sd_multi_req_arbiter;

  localparam logic [1:0] WMASK = 2'b01;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_rd = '0, req_wr = '0, img_mounted = '0, sd_ack = '0;
  logic [63:0] img_size = '0;
  logic        img_readonly = 1'b0;
  logic [1:0]  sd_rd, sd_wr, mounted, protect, done, err, active_ch;
  logic        cpu_wait, active;

  typedef struct packed {logic [1:0] ch; logic wr; logic is_err;} exp_t;
  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_mis = 0;

  sd_multi_req_arbiter #(
    .NCH            (2),
    .WAIT_MASK      (WMASK),
    .TIMEOUT_CYCLES (24'd100)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .img_mounted  (img_mounted),
    .img_size     (img_size),
    .img_readonly (img_readonly),
    .sd_ack       (sd_ack),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .mounted      (mounted),
    .protect      (protect),
    .cpu_wait     (cpu_wait),
    .active       (active),
    .active_ch    (active_ch),
    .done         (done),
    .err          (err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(negedge clk_sys);
  endtask

  function automatic exp_t pop_exp();
    if (sb.size() == 0) return '{ch: 2'd3, wr: 1'b1, is_err: 1'b1};
    return sb.pop_front();
  endfunction

  task automatic mount(input logic ch, input logic [63:0] size, input logic ro);
    img_mounted  = 2'b01 << ch;
    img_size     = size;
    img_readonly = ro;
    tick();
    img_mounted  = '0;
  endtask

  task automatic request(input logic [1:0] rd, input logic [1:0] wr);
    req_rd = rd;
    req_wr = wr;
    tick();
    req_rd = '0;
    req_wr = '0;
  endtask

  // Plays hps_io for one grant: waits for sd_rd/sd_wr, holds ack, reports what it saw.
  task automatic serve(input int hold, output bit found, output logic [1:0] ch,
                       output logic [1:0] rd, output logic [1:0] wr, output logic cw,
                       output logic [1:0] req_after, output logic [1:0] dn,
                       output logic cw_after, output logic act_after);
    found = 0; ch = '0; rd = '0; wr = '0; cw = 1'b0; req_after = '0;
    dn = '0; cw_after = 1'b0; act_after = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if ((sd_rd | sd_wr) != 2'b00) begin
        found = 1;
        break;
      end
      tick();
    end
    if (!found) return;
    rd = sd_rd; wr = sd_wr; ch = active_ch; cw = cpu_wait;
    sd_ack = 2'b01 << ch;
    tick();
    req_after = sd_rd | sd_wr;
    repeat (hold - 1) tick();
    sd_ack = '0;
    tick();
    dn = done; cw_after = cpu_wait; act_after = active;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({sd_rd, sd_wr, mounted, protect, cpu_wait, active, active_ch, done, err} !== 16'h0) begin
      n_mis++;
      $display("FAIL reset_state: outputs=%h want 0000",
               {sd_rd, sd_wr, mounted, protect, cpu_wait, active, active_ch, done, err});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mount();
    mount(1'b0, 64'd512, 1'b0);
    mount(1'b1, 64'd0, 1'b0);
    n_cmp++;
    if (mounted !== 2'b01 || protect !== 2'b00) begin
      n_mis++;
      $display("FAIL mount_zero: mounted=%b protect=%b want 01/00", mounted, protect);
    end
    // Any request to an empty drive is rejected.
    sb.push_back('{ch: 2'd1, wr: 1'b0, is_err: 1'b1});
    request(2'b10, 2'b00);
    e = pop_exp();
    n_cmp++;
    if (!e.is_err || err !== (2'b01 << e.ch) || active !== 1'b0 || sd_rd !== 2'b00) begin
      n_mis++;
      $display("FAIL unmounted_err: err=%b active=%b sd_rd=%b want 10/0/00", err, active, sd_rd);
    end
    mount(1'b1, 64'd4096, 1'b1);
    n_cmp++;
    if (mounted !== 2'b11 || protect !== 2'b10) begin
      n_mis++;
      $display("FAIL mount_ro: mounted=%b protect=%b want 11/10", mounted, protect);
    end
  endtask

  task automatic test_read();
    bit f;
    logic [1:0] ch, rd, wr, ra, dn;
    logic cw, cwa, aa;
    sb.push_back('{ch: 2'd0, wr: 1'b0, is_err: 1'b0});
    request(2'b01, 2'b00);
    n_cmp++;
    if (sd_rd !== 2'b00) begin
      n_mis++;
      $display("FAIL read_lat1: sd_rd=%b want 00 one cycle after request", sd_rd);
    end
    tick();
    n_cmp++;
    if (sd_rd !== 2'b01 || sd_wr !== 2'b00 || cpu_wait !== 1'b1 || active !== 1'b1) begin
      n_mis++;
      $display("FAIL read_grant: sd_rd=%b sd_wr=%b cpu_wait=%b active=%b want 01/00/1/1",
               sd_rd, sd_wr, cpu_wait, active);
    end
    serve(10, f, ch, rd, wr, cw, ra, dn, cwa, aa);
    n_cmp++;
    if (!f || ra !== 2'b00) begin
      n_mis++;
      $display("FAIL read_ack_clear: found=%0d req_after_ack=%b want 1/00", f, ra);
    end
    n_cmp++;
    if (dn !== 2'b01 || cwa !== 1'b0 || aa !== 1'b0) begin
      n_mis++;
      $display("FAIL read_done: done=%b cpu_wait=%b active=%b want 01/0/0", dn, cwa, aa);
    end
    e = pop_exp();
    n_cmp++;
    if (e.is_err || ch !== e.ch || (wr != 2'b00) !== e.wr || dn !== (2'b01 << e.ch)) begin
      n_mis++;
      $display("FAIL read_sb: ch=%0d wr=%b done=%b want ch=%0d wr=%b", ch, wr, dn, e.ch, e.wr);
    end
    tick();
    n_cmp++;
    if (done !== 2'b00) begin
      n_mis++;
      $display("FAIL read_done_pulse: done=%b want 00 after one cycle", done);
    end
  endtask

  task automatic test_protect();
    sb.push_back('{ch: 2'd1, wr: 1'b1, is_err: 1'b1});
    request(2'b00, 2'b10);
    e = pop_exp();
    n_cmp++;
    if (!e.is_err || err !== (2'b01 << e.ch) || sd_wr !== 2'b00 || active !== 1'b0) begin
      n_mis++;
      $display("FAIL protect_err: err=%b sd_wr=%b active=%b want 10/00/0", err, sd_wr, active);
    end
    tick();
    n_cmp++;
    if (err !== 2'b00 || sd_wr !== 2'b00 || active !== 1'b0) begin
      n_mis++;
      $display("FAIL protect_after: err=%b sd_wr=%b active=%b want 00/00/0", err, sd_wr, active);
    end
  endtask

  task automatic test_round_robin();
    bit f;
    logic [1:0] ch, rd, wr, ra, dn;
    logic cw, cwa, aa;
    // A lone drive-1 read moves rr back to 0 and must not stall the CPU.
    sb.push_back('{ch: 2'd1, wr: 1'b0, is_err: 1'b0});
    request(2'b10, 2'b00);
    serve(3, f, ch, rd, wr, cw, ra, dn, cwa, aa);
    e = pop_exp();
    n_cmp++;
    if (!f || ch !== e.ch || rd !== 2'b10 || cw !== 1'b0 || dn !== (2'b01 << e.ch)) begin
      n_mis++;
      $display("FAIL rr_prime: found=%0d ch=%0d sd_rd=%b cpu_wait=%b done=%b want 1/1/10/0/10",
               f, ch, rd, cw, dn);
    end
    for (int r = 0; r < 2; r++) begin
      sb.push_back('{ch: 2'd0, wr: 1'b0, is_err: 1'b0});
      sb.push_back('{ch: 2'd1, wr: 1'b0, is_err: 1'b0});
      request(2'b11, 2'b00);
      for (int j = 0; j < 2; j++) begin
        serve(3, f, ch, rd, wr, cw, ra, dn, cwa, aa);
        e = pop_exp();
        n_cmp++;
        if (!f || e.is_err || ch !== e.ch || rd !== (2'b01 << e.ch) || wr !== 2'b00 ||
            cw !== |(WMASK & (2'b01 << e.ch)) || dn !== (2'b01 << e.ch) || cwa !== 1'b0) begin
          n_mis++;
          $display("FAIL rr_order[%0d.%0d]: found=%0d ch=%0d sd_rd=%b cpu_wait=%b done=%b want ch=%0d",
                   r, j, f, ch, rd, cw, dn, e.ch);
        end
      end
    end
  endtask

  task automatic test_rd_wr();
    bit f;
    logic [1:0] ch, rd, wr, ra, dn;
    logic cw, cwa, aa;
    int n_done = 0;
    sb.push_back('{ch: 2'd0, wr: 1'b0, is_err: 1'b0});
    sb.push_back('{ch: 2'd0, wr: 1'b1, is_err: 1'b0});
    request(2'b01, 2'b01);
    for (int j = 0; j < 2; j++) begin
      serve(4, f, ch, rd, wr, cw, ra, dn, cwa, aa);
      e = pop_exp();
      if (dn[0] === 1'b1) n_done++;
      n_cmp++;
      if (!f || ch !== e.ch || (e.wr ? wr : rd) !== 2'b01 || (e.wr ? rd : wr) !== 2'b00 ||
          dn !== 2'b01) begin
        n_mis++;
        $display("FAIL rdwr_grant[%0d]: found=%0d ch=%0d sd_rd=%b sd_wr=%b done=%b want wr=%b",
                 j, f, ch, rd, wr, dn, e.wr);
      end
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done[0] === 1'b1) n_done++;
    end
    n_cmp++;
    if (n_done != 2 || sd_rd !== 2'b00 || sd_wr !== 2'b00) begin
      n_mis++;
      $display("FAIL rdwr_count: done pulses=%0d sd_rd=%b sd_wr=%b want 2/00/00",
               n_done, sd_rd, sd_wr);
    end
  endtask

  task automatic test_back_to_back();
    bit f;
    logic [1:0] ch, rd, wr, ra, dn;
    logic cw, cwa, aa;
    bit extra = 0;
    sb.push_back('{ch: 2'd0, wr: 1'b0, is_err: 1'b0});
    sb.push_back('{ch: 2'd1, wr: 1'b0, is_err: 1'b0});
    request(2'b01, 2'b00);
    tick();
    // Two pulses for drive 1 while drive 0 is busy collapse into one grant.
    request(2'b10, 2'b00);
    request(2'b10, 2'b00);
    tick();
    for (int j = 0; j < 2; j++) begin
      serve(3, f, ch, rd, wr, cw, ra, dn, cwa, aa);
      e = pop_exp();
      n_cmp++;
      if (!f || ch !== e.ch || rd !== (2'b01 << e.ch) || dn !== (2'b01 << e.ch)) begin
        n_mis++;
        $display("FAIL busy_grant[%0d]: found=%0d ch=%0d sd_rd=%b done=%b want ch=%0d",
                 j, f, ch, rd, dn, e.ch);
      end
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      if ((sd_rd | sd_wr) != 2'b00 || active !== 1'b0) extra = 1;
    end
    n_cmp++;
    if (extra) begin
      n_mis++;
      $display("FAIL busy_collapse: extra grant seen=%0d want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    request(2'b01, 2'b00);
    tick();
    sd_ack = 2'b01;
    tick();
    request(2'b10, 2'b00);
    tick();
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({sd_rd, sd_wr, mounted, protect, cpu_wait, active, active_ch, done, err} !== 16'h0) begin
      n_mis++;
      $display("FAIL reset_async: outputs=%h want 0000 before any clock edge",
               {sd_rd, sd_wr, mounted, protect, cpu_wait, active, active_ch, done, err});
    end
    tick();
    sd_ack = '0;
    reset  = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done !== 2'b00 || (sd_rd | sd_wr) !== 2'b00 || active !== 1'b0) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_mis++;
      $display("FAIL reset_flush: done/grant after reset seen=%0d want 0", seen);
    end
  endtask

`ifdef SD_REQ_TIMEOUT_EN
  task automatic test_timeout();
    int k = 0;
    mount(1'b0, 64'd512, 1'b0);
    sb.push_back('{ch: 2'd0, wr: 1'b0, is_err: 1'b1});
    request(2'b01, 2'b00);
    tick();
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (err !== 2'b00) begin
        k = c;
        break;
      end
    end
    e = pop_exp();
    n_cmp++;
    if (k != 100 || !e.is_err || err !== (2'b01 << e.ch) || sd_rd !== 2'b00 ||
        cpu_wait !== 1'b0 || active !== 1'b0 || done !== 2'b00) begin
      n_mis++;
      $display("FAIL timeout: cycles=%0d err=%b sd_rd=%b cpu_wait=%b done=%b want 100/01/00/0/00",
               k, err, sd_rd, cpu_wait, done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mount();
    test_read();
    test_protect();
    test_round_robin();
    test_rd_wr();
    test_back_to_back();
    test_reset_mid();
`ifdef SD_REQ_TIMEOUT_EN
    test_timeout();
`endif
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL scoreboard_drain: %0d expected completions left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sd_multi_req_arbiter.md
Name: sd_multi_req_arbiter

Overview:
- Generalised block-device request handler between the core's disk controllers and the hps_io SD interface (sd_rd/sd_wr/sd_ack per virtual drive).
- Latches read/write requests from NCH drives, arbitrates them round-robin and runs a single rd/wr/ack handshake at a time.
- Tracks mount and write-protect state per drive and holds the CPU (cpu_wait) for drives selected in WAIT_MASK.
- Sits in emu beside hps_io; replaces the single-drive HDD handshake logic.

Parameters:
- NCH, 2, number of virtual drives; matches hps_io VDNUM; range 1..4.
- WAIT_MASK, 2'b01, bit i set means a transfer on drive i asserts cpu_wait; width NCH.
- TIMEOUT_CYCLES, 24'd5000000, watchdog limit in clk_sys cycles; used only with SD_REQ_TIMEOUT_EN.

Ports:
- clk_sys, input, 1, system clock.
- reset, input, 1, asynchronous, active-high.
- req_rd, input, NCH, per-drive single-cycle read request pulse.
- req_wr, input, NCH, per-drive single-cycle write request pulse.
- img_mounted, input, NCH, hps_io mount strobe per drive.
- img_size, input, 64, image size qualifying img_mounted.
- img_readonly, input, 1, readonly flag qualifying img_mounted.
- sd_ack, input, NCH, hps_io acknowledge per drive.
- sd_rd, output, NCH, read request to hps_io.
- sd_wr, output, NCH, write request to hps_io.
- mounted, output, NCH, drive has a non-zero image.
- protect, output, NCH, drive is write-protected.
- cpu_wait, output, 1, CPU stall.
- active, output, 1, handshake in progress.
- active_ch, output, 2, index of the granted drive.
- done, output, NCH, 1-cycle completion pulse per drive.
- err, output, NCH, 1-cycle pulse for a rejected or aborted request.

Behaviour:
- Reset (async, any state): all outputs 0; pending_rd, pending_wr, rr pointer, state and timer cleared; state goes to IDLE; in-flight transfer abandoned with no done pulse.
- Mount: on img_mounted[i], mounted[i] <= (img_size != 0) and protect[i] <= img_readonly, registered. Takes effect even mid-transfer; does not abort a transfer in progress.
- Pending latch: every cycle, pending_rd |= req_rd and pending_wr |= req_wr.
  - A write on a drive with protect=1 is not latched; err[i] pulses the next cycle.
  - Any request on a drive with mounted=0 is not latched; err[i] pulses the next cycle.
- ack_q: registered copy of sd_ack; edges are detected against it.
- IDLE:
  - Search starts at rr and wraps modulo NCH; the first drive i with pending_rd[i] or pending_wr[i] is granted.
  - Next cycle: active_ch <= i, active <= 1, state <= REQ.
  - If both reads and writes are pending on i, the read is issued and the write stays pending. Exactly one of sd_rd[i] or sd_wr[i] is set.
  - cpu_wait <= WAIT_MASK[i].
  - rr <= (i+1) mod NCH.
- REQ: on a rising edge of sd_ack[active_ch]:
  - Clear sd_rd/sd_wr and the pending bit of the issued type.
  - state <= XFER.
  - A new request of the same type arriving in that cycle is re-latched; set wins over clear.
- XFER: on a falling edge of sd_ack[active_ch], in the next cycle:
  - done[active_ch] pulses.
  - cpu_wait <= 0, active <= 0.
  - state <= IDLE.
  - Minimum IDLE dwell is 1 cycle before the next grant.
- sd_ack on a non-granted drive is ignored.
- Latency: request pulse to sd_rd/sd_wr high is 2 cycles when idle. sd_ack fall to done is 1 cycle.
- Requests arriving while busy stay pending and are not lost; multiple pulses of the same type collapse into one.

Optional Feature:
- Macro: SD_REQ_TIMEOUT_EN.
- Defined:
  - A 24-bit timer clears on entering REQ and counts in REQ and XFER.
  - When it reaches TIMEOUT_CYCLES, sd_rd/sd_wr are dropped and err[active_ch] pulses with no done. cpu_wait and active go to 0 and state goes to IDLE.
  - The pending bit of the issued type is cleared.
  - Stray ack edges from the aborted drive while IDLE are ignored.
- Not defined: no timer logic; the block waits on sd_ack indefinitely.

Test Plan:
- Mount drive0 with img_size=512, img_readonly=0, then pulse req_rd[0]:
  - Expect sd_rd=2'b01 2 cycles later, cpu_wait=1.
  - Raise sd_ack[0] for 10 cycles, then drop it.
  - Expect done[0] pulse 1 cycle after the fall, cpu_wait=0.
- Drive1 protected (img_readonly=1), pulse req_wr[1] -> err[1] pulse, sd_wr stays 0, active stays 0.
- req_rd[0] and req_rd[1] in the same cycle with rr=0:
  - Expect drive0 served first, then drive1.
  - For drive1, cpu_wait stays 0 because WAIT_MASK=2'b01.
  - rr ends at 0.
- req_rd[0] and req_wr[0] together:
  - Read is issued first.
  - After done, a second grant issues sd_wr[0].
  - Exactly 2 done[0] pulses.
- Assert reset mid-XFER (sd_ack[0]=1):
  - All outputs 0 immediately, without waiting for a clock edge.
  - Pending bits cleared.
  - No done after reset is released.
- With SD_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=100: grant a read and never ack it -> err[0] pulse at cycle 100 after REQ entry, sd_rd=0, cpu_wait=0.
